// File: rtl/player_control.sv
// Player paddle controller: debounces two push-buttons, runs an IDLE/LEFT/RIGHT FSM
// and steps the box position once per frame on the vsync falling edge, clamped to the screen.
module key_debounce #(
    parameter logic [17:0] DEBOUNCE_CYCLES = 18'd250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level
);
    localparam logic [17:0] DB_LAST = DEBOUNCE_CYCLES - 18'd1;

    logic        sync1, sync2;
    logic [17:0] cnt;

    // Released (high) is the reset level for the whole chain, so no phantom press after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 18'd1;
            end
        end
    end
endmodule

module player_control #(
    parameter logic [9:0]  BOX_WIDTH       = 10'd30,
    parameter logic [9:0]  MOVE_STEP       = 10'd4,
    parameter logic [9:0]  SCREEN_WIDTH    = 10'd640,
    parameter logic [9:0]  X_START         = 10'd305,
    parameter logic [17:0] DEBOUNCE_CYCLES = 18'd250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       vsync,
    output logic [9:0] player_x,
    output logic       moving,
    output logic       at_edge
);
    localparam logic [10:0] X_MAX = {1'b0, SCREEN_WIDTH} - {1'b0, BOX_WIDTH};
    localparam logic [10:0] STEP  = {1'b0, MOVE_STEP};

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    logic   deb_left, deb_right;
    logic   left_p, right_p;
    state_t state, state_nxt, dir_q;
    logic   vsync_q, tick, tick_d;
    logic   [10:0] x11;
    logic   [9:0]  x_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst(rst), .key_n(key_left_n), .level(deb_left)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst(rst), .key_n(key_right_n), .level(deb_right)
    );

    assign left_p  = ~deb_left;
    assign right_p = ~deb_right;

    always_comb begin
        state_nxt = IDLE;
        if (left_p && !right_p)
            state_nxt = LEFT;
        else if (right_p && !left_p)
            state_nxt = RIGHT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            moving <= 1'b0;
        end else begin
            state  <= state_nxt;
            moving <= (state_nxt != IDLE);
        end
    end

    // Direction is latched at the tick so key changes mid-frame only affect the next frame.
    assign tick = vsync_q & ~vsync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q <= 1'b1;
            tick_d  <= 1'b0;
            dir_q   <= IDLE;
        end else begin
            vsync_q <= vsync;
            tick_d  <= tick;
            if (tick)
                dir_q <= state;
        end
    end

    // 11-bit compares keep both clamps wrap-free near 0 and X_MAX.
    assign x11 = {1'b0, player_x};

    always_comb begin
        x_nxt = player_x;
        if (tick_d) begin
            case (dir_q)
                LEFT:    x_nxt = (x11 < STEP) ? 10'd0 : 10'(x11 - STEP);
                RIGHT:   x_nxt = ((x11 + STEP) > X_MAX) ? X_MAX[9:0] : 10'(x11 + STEP);
                default: x_nxt = player_x;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            player_x <= X_START;
        else
            player_x <= x_nxt;
    end

    assign at_edge = (player_x == 10'd0) || (x11 == X_MAX);
endmodule

// File: tb/tb_player_control.sv
// Randomised + directed bench: a frame-level reference model pushes expected outputs every
// clock into a scoreboard queue; an independent monitor pops and compares on the falling edge.
module tb_player_control;
    localparam int FRAME = 16;
    localparam int XMAX  = 640 - 30;
    localparam int STEP  = 4;
    localparam int XST   = 305;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_left_n, key_right_n, vsync;
    logic [9:0] player_x;
    logic       moving, at_edge;

    player_control #(.DEBOUNCE_CYCLES(18'd4)) dut (
        .clk(clk), .rst(rst), .key_left_n(key_left_n), .key_right_n(key_right_n),
        .vsync(vsync), .player_x(player_x), .moving(moving), .at_edge(at_edge)
    );

    always #5 clk = ~clk;

    typedef struct {int x; bit mv; bit ae;} exp_t;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ph = 0;

    // Reference model: key counts as changed after 4 consecutive differing samples, seen
    // 2 clocks later; the FSM follows one clock behind; moves land one clock after a tick.
    bit [5:0] m_hl, m_hr;
    bit       m_deb_l, m_deb_r, m_vq, m_pend;
    int       m_state, m_dir, m_x;

    task automatic m_reset();
        m_hl = 6'h3f; m_hr = 6'h3f;
        m_deb_l = 1'b1; m_deb_r = 1'b1; m_vq = 1'b1; m_pend = 1'b0;
        m_state = 0; m_dir = 0; m_x = XST;
    endtask

    function automatic exp_t m_exp();
        exp_t e;
        e.x  = m_x;
        e.mv = (m_state != 0);
        e.ae = (m_x == 0) || (m_x == XMAX);
        return e;
    endfunction

    task automatic m_step();
        int ns;
        bit tk;
        if (!m_deb_l && m_deb_r)      ns = 1;
        else if (m_deb_l && !m_deb_r) ns = 2;
        else                          ns = 0;
        m_hl = {m_hl[4:0], key_left_n};
        m_hr = {m_hr[4:0], key_right_n};
        if (m_hl[5:2] == {4{~m_deb_l}}) m_deb_l = ~m_deb_l;
        if (m_hr[5:2] == {4{~m_deb_r}}) m_deb_r = ~m_deb_r;
        tk   = m_vq && !vsync;
        m_vq = vsync;
        if (m_pend) begin
            if (m_dir == 1)      m_x = (m_x < STEP) ? 0 : m_x - STEP;
            else if (m_dir == 2) m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
        end
        m_pend = tk;
        if (tk) m_dir = m_state;
        m_state = ns;
    endtask

    always @(posedge clk) begin
        if (!rst) m_reset();
        else      m_step();
        q.push_back(m_exp());
    end

    // Reset is asynchronous: drop stale expectations and expect the reset values at once.
    always @(negedge rst) begin
        m_reset();
        q.delete();
        q.push_back(m_exp());
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (player_x !== 10'(e.x) || moving !== e.mv || at_edge !== e.ae) begin
                errors++;
                if (errors < 30)
                    $display("FAIL outputs t=%0t got x=%0d mv=%b edge=%b want x=%0d mv=%b edge=%b",
                             $time, player_x, moving, at_edge, e.x, e.mv, e.ae);
            end
        end
    end

    task automatic cyc(input bit l, input bit r);
        @(negedge clk);
        key_left_n  = l;
        key_right_n = r;
        vsync       = (ph < FRAME - 3);
        ph          = (ph + 1) % FRAME;
    endtask

    task automatic frames(input int n, input bit l, input bit r);
        repeat (n * FRAME) cyc(l, r);
    endtask

    task automatic pulse_reset(input int len, input bit l, input bit r);
        @(posedge clk); #2 rst = 1'b0;
        repeat (len) cyc(l, r);
        @(posedge clk); #2 rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time bound");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        m_reset();
        rst = 1'b0; key_left_n = 1'b1; key_right_n = 1'b1; vsync = 1'b1;
        repeat (4) cyc(1, 1);
        @(posedge clk); #2 rst = 1'b1;

        frames(10, 1, 1);           // no keys: position holds at start
        frames(4, 1, 0);            // right: 309, 313, 317 ...
        frames(80, 1, 0);           // into the right clamp and hold at 610
        frames(160, 0, 1);          // down through 2 into the left clamp at 0
        frames(155, 1, 0);          // 0 -> 608 -> 610
        repeat (3) cyc(0, 1);       // short left glitch
        repeat (40) cyc(1, 1);
        for (int i = 0; i < 48; i++) cyc(i[0], 1);  // bouncing left key
        repeat (40) cyc(1, 1);
        frames(3, 0, 0);            // both pressed -> IDLE
        frames(20, 0, 1);
        frames(3, 1, 0);
        repeat (7) cyc(1, 0);
        pulse_reset(3, 1, 0);       // reset while moving right mid-frame
        frames(3, 1, 0);

        for (int s = 0; s < 300; s++) begin
            int  len;
            bit  l, r;
            len = $urandom_range(1, 40);
            l   = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0)
                pulse_reset($urandom_range(1, 3), l, r);
            repeat (len) cyc(l, r);
        end

        repeat (10) cyc(1, 1);
        if (checks < 1000) begin
            errors++;
            $display("FAIL check_count got %0d want >= 1000", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
